sram_rr_arbiter: RTL and testbench

- Shares one port of the dual-port SRAM block among `NUM_REQ` requesters using round-robin arbitration.
- Accepts at most one access per cycle, drives the SRAM port enable, write-enable, address and data, and returns read data to the winning requester.
- Sits between pipeline clients (fetch, load/store, debug/DMA) and one port of an on-chip SRAM.
- The SRAM's other port stays private to a single client.

---
 rtl/sram_arb_pkg.sv | 31 +++
 rtl/sram_rr_arbiter_if.sv | 30 +++
 rtl/rr_picker.sv | 24 ++
 rtl/sram_rr_arbiter.sv | 100 ++++++++++
 tb/tb_sram_rr_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants and the rotating first-set search used by the SRAM round-robin arbiter.
package sram_arb_pkg;

  localparam int unsigned DefNumReq   = 4;
  localparam int unsigned DefRamWidth = 40;
  localparam int unsigned DefAddrBits = 16;
  localparam int unsigned MaxReq      = 8;

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of req, searching from ptr upward and wrapping modulo n.
  function automatic int unsigned rr_first(logic [MaxReq-1:0] req, int unsigned ptr,
                                           int unsigned n);
    int unsigned idx;
    int unsigned res;
    logic        found;
    res   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      idx = (ptr + i) % n;
      if (i < n && !found && req[idx[2:0]]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_rr_arbiter_if.sv
// Requester-side and SRAM-side signals of the arbiter; slave is the arbiter's view.
interface sram_rr_arbiter_if import sram_arb_pkg::*; #(
  parameter int unsigned NUM_REQ       = DefNumReq,
  parameter int unsigned RAM_WIDTH     = DefRamWidth,
  parameter int unsigned RAM_ADDR_BITS = DefAddrBits
);
  logic [NUM_REQ-1:0]               req_i;
  logic [NUM_REQ-1:0]               we_i;
  logic [NUM_REQ-1:0]               lock_i;
  logic [NUM_REQ*RAM_ADDR_BITS-1:0] addr_i;
  logic [NUM_REQ*RAM_WIDTH-1:0]     wdata_i;
  logic [NUM_REQ-1:0]               gnt_o;
  logic [NUM_REQ-1:0]               rvalid_o;
  logic [RAM_WIDTH-1:0]             rdata_o;
  logic                             sram_en_o;
  logic                             sram_we_o;
  logic [RAM_ADDR_BITS-1:0]         sram_addr_o;
  logic [RAM_WIDTH-1:0]             sram_wdata_o;
  logic [RAM_WIDTH-1:0]             sram_rdata_i;

  modport slave (
    input  req_i, we_i, lock_i, addr_i, wdata_i, sram_rdata_i,
    output gnt_o, rvalid_o, rdata_o, sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o
  );

  modport master (
    output req_i, we_i, lock_i, addr_i, wdata_i, sram_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin pick: one-hot grant and index of the first request from ptr_i.
module rr_picker import sram_arb_pkg::*; #(
  parameter int unsigned NUM_REQ = DefNumReq,
  localparam int unsigned IdxW   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o,
  output logic               valid_o
);
  logic [MaxReq-1:0] req_ext;
  logic [31:0]       first;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req_i;
    first                  = rr_first(req_ext, 32'(ptr_i), NUM_REQ);
    idx_o                  = first[IdxW-1:0];
    valid_o                = |req_i;
    gnt_o                  = '0;
    gnt_o[idx_o]           = valid_o;
  end
endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one SRAM port among NUM_REQ requesters.
// Optional ownership lock built when SRAM_ARB_LOCK_EN is defined.
module sram_rr_arbiter import sram_arb_pkg::*; #(
  parameter int unsigned NUM_REQ       = DefNumReq,
  parameter int unsigned RAM_WIDTH     = DefRamWidth,
  parameter int unsigned RAM_ADDR_BITS = DefAddrBits
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  sram_rr_arbiter_if.slave   bus
);
  localparam int unsigned IdxW = idx_width(NUM_REQ);

  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] rd_tag_q, rd_tag_d;
  logic [NUM_REQ-1:0] elig, pick_gnt;
  logic [IdxW-1:0]    pick_idx, sel;
  logic               pick_vld, grant;

`ifdef SRAM_ARB_LOCK_EN
  logic [IdxW-1:0] owner_q, owner_d;
  logic            owner_vld_q, owner_vld_d;

  always_comb begin
    elig = bus.req_i;
    if (owner_vld_q) elig = bus.req_i & (NUM_REQ'(1) << owner_q);
  end

  always_comb begin
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    if (grant) begin
      if (bus.lock_i[pick_idx]) begin
        owner_d     = pick_idx;
        owner_vld_d = 1'b1;
      end else if (owner_vld_q) begin
        // While owned, any grant is to the owner, so an unlocked grant releases it.
        owner_vld_d = 1'b0;
      end
    end else if (owner_vld_q && !bus.req_i[owner_q] && !bus.lock_i[owner_q]) begin
      owner_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock_i;
  assign elig        = bus.req_i;
`endif

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i   (elig),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

  always_comb begin
    grant            = pick_vld & rst_ni;
    sel              = pick_vld ? pick_idx : '0;
    bus.gnt_o        = grant ? pick_gnt : '0;
    bus.sram_en_o    = grant;
    bus.sram_we_o    = grant & bus.we_i[sel];
    bus.sram_addr_o  = bus.addr_i[sel*RAM_ADDR_BITS +: RAM_ADDR_BITS];
    bus.sram_wdata_o = bus.wdata_i[sel*RAM_WIDTH +: RAM_WIDTH];
    bus.rvalid_o     = rst_ni ? rd_tag_q : '0;
    bus.rdata_o      = bus.sram_rdata_i;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    rd_tag_d = '0;
    if (grant) begin
      rr_ptr_d = (32'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
      if (!bus.we_i[pick_idx]) rd_tag_d = pick_gnt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      rd_tag_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rd_tag_q <= rd_tag_d;
    end
  end
endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter with a write-first SRAM model on the shared port.
module tb_sram_rr_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 40;
  localparam int unsigned AW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [N-1:0]  req, we, lock;
  logic [AW-1:0] addr  [N];
  logic [DW-1:0] wdata [N];
  logic [DW-1:0] mem   [0:65535];
  logic [DW-1:0] ram_q;

  int n_cmp  = 0;
  int n_fail = 0;

  sram_rr_arbiter_if #(.NUM_REQ(N), .RAM_WIDTH(DW), .RAM_ADDR_BITS(AW)) bus ();

  sram_rr_arbiter #(.NUM_REQ(N), .RAM_WIDTH(DW), .RAM_ADDR_BITS(AW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.req_i        = req;
    bus.we_i         = we;
    bus.lock_i       = lock;
    bus.addr_i       = '0;
    bus.wdata_i      = '0;
    for (int k = 0; k < N; k++) begin
      bus.addr_i[k*AW +: AW]  = addr[k];
      bus.wdata_i[k*DW +: DW] = wdata[k];
    end
    bus.sram_rdata_i = ram_q;
  end

  always @(posedge clk) begin
    if (bus.sram_en_o) begin
      if (bus.sram_we_o) begin
        mem[bus.sram_addr_o] <= bus.sram_wdata_o;
        ram_q                <= bus.sram_wdata_o;
      end else begin
        ram_q <= mem[bus.sram_addr_o];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    we    = '0;
    lock  = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    we    = '0;
    lock  = '0;
    for (int k = 0; k < N; k++) addr[k] = 16'h0020 + 16'(k);
    #2;
    n_cmp++; if (bus.gnt_o !== 4'b0000) begin
      $display("FAIL reset_gnt: got %b want 0000", bus.gnt_o); n_fail++; end
    n_cmp++; if (bus.sram_en_o !== 1'b0) begin
      $display("FAIL reset_en: got %b want 0", bus.sram_en_o); n_fail++; end
    tick();
    n_cmp++; if (bus.rvalid_o !== 4'b0000) begin
      $display("FAIL reset_rvalid: got %b want 0000", bus.rvalid_o); n_fail++; end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.gnt_o !== 4'b0001) begin
      $display("FAIL reset_first_gnt: got %b want 0001", bus.gnt_o); n_fail++; end
    tick();
    n_cmp++; if (bus.rvalid_o !== 4'b0001) begin
      $display("FAIL reset_first_rvalid: got %b want 0001", bus.rvalid_o); n_fail++; end
    req = '0;
  endtask

  task automatic test_single_read();
    do_reset();
    req     = 4'b0100;
    addr[2] = 16'h0010;
    #1;
    n_cmp++; if (bus.gnt_o !== 4'b0100) begin
      $display("FAIL single_gnt: got %b want 0100", bus.gnt_o); n_fail++; end
    n_cmp++; if (bus.sram_addr_o !== 16'h0010 || bus.sram_we_o !== 1'b0) begin
      $display("FAIL single_port: got addr %h we %b want addr 0010 we 0",
               bus.sram_addr_o, bus.sram_we_o); n_fail++; end
    tick();
    req = '0;
    n_cmp++; if (bus.rvalid_o !== 4'b0100) begin
      $display("FAIL single_rvalid: got %b want 0100", bus.rvalid_o); n_fail++; end
    n_cmp++; if (bus.rdata_o !== 40'hAB_CDEF_0123) begin
      $display("FAIL single_rdata: got %h want abcdef0123", bus.rdata_o); n_fail++; end
    #1;
    n_cmp++; if (bus.sram_en_o !== 1'b0 || bus.gnt_o !== 4'b0000) begin
      $display("FAIL idle_outputs: got en %b gnt %b want en 0 gnt 0000",
               bus.sram_en_o, bus.gnt_o); n_fail++; end
    tick();
    n_cmp++; if (bus.rvalid_o !== 4'b0000) begin
      $display("FAIL single_rvalid_drop: got %b want 0000", bus.rvalid_o); n_fail++; end
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_g;
    logic [DW-1:0] exp_d;
    do_reset();
    for (int k = 0; k < N; k++) addr[k] = 16'h0020 + 16'(k);
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      exp_g = 4'b0001 << (i % 4);
      exp_d = 40'h10_0000_00A0 + 40'(i % 4);
      #1;
      n_cmp++; if (bus.gnt_o !== exp_g) begin
        $display("FAIL contention_gnt[%0d]: got %b want %b", i, bus.gnt_o, exp_g); n_fail++; end
      tick();
      n_cmp++; if (bus.rvalid_o !== exp_g || bus.rdata_o !== exp_d) begin
        $display("FAIL contention_rd[%0d]: got rvalid %b data %h want %b %h",
                 i, bus.rvalid_o, bus.rdata_o, exp_g, exp_d); n_fail++; end
    end
    req = '0;
  endtask

  task automatic test_write_read();
    do_reset();
    req      = 4'b0010;
    we       = 4'b0010;
    addr[1]  = 16'h0003;
    wdata[1] = 40'h55;
    #1;
    n_cmp++; if (bus.gnt_o !== 4'b0010 || bus.sram_we_o !== 1'b1) begin
      $display("FAIL wr_gnt: got gnt %b we %b want 0010 1", bus.gnt_o, bus.sram_we_o); n_fail++; end
    tick();
    req     = 4'b1000;
    we      = 4'b0000;
    addr[3] = 16'h0003;
    n_cmp++; if (bus.rvalid_o !== 4'b0000) begin
      $display("FAIL wr_no_rvalid: got %b want 0000", bus.rvalid_o); n_fail++; end
    #1;
    n_cmp++; if (bus.gnt_o !== 4'b1000) begin
      $display("FAIL rd_after_wr_gnt: got %b want 1000", bus.gnt_o); n_fail++; end
    tick();
    req = '0;
    n_cmp++; if (bus.rvalid_o !== 4'b1000 || bus.rdata_o !== 40'h55) begin
      $display("FAIL rd_after_wr: got rvalid %b data %h want 1000 55",
               bus.rvalid_o, bus.rdata_o); n_fail++; end
  endtask

  task automatic test_lock();
    logic [N-1:0] exp_seq [5];
`ifdef SRAM_ARB_LOCK_EN
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
`else
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      lock = (i < 3) ? 4'b0001 : 4'b0000;
      #1;
      n_cmp++; if (bus.gnt_o !== exp_seq[i]) begin
        $display("FAIL lock_gnt[%0d]: got %b want %b", i, bus.gnt_o, exp_seq[i]); n_fail++; end
      tick();
    end
    req  = '0;
    lock = '0;
  endtask

  task automatic test_wrap_single();
    do_reset();
    req = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.gnt_o !== 4'b1000) begin
        $display("FAIL single_req_gnt[%0d]: got %b want 1000", i, bus.gnt_o); n_fail++; end
      tick();
    end
    // Pointer wrapped past index 3, so requester 0 must win over 3.
    req = 4'b1001;
    #1;
    n_cmp++; if (bus.gnt_o !== 4'b0001) begin
      $display("FAIL wrap_gnt: got %b want 0001", bus.gnt_o); n_fail++; end
    tick();
    req = '0;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    req     = 4'b0100;
    addr[2] = 16'h0010;
    #1;
    n_cmp++; if (bus.gnt_o !== 4'b0100) begin
      $display("FAIL midrst_gnt: got %b want 0100", bus.gnt_o); n_fail++; end
    tick();
    rst_n = 1'b0;
    req   = '0;
    #1;
    n_cmp++; if (bus.rvalid_o !== 4'b0000) begin
      $display("FAIL midrst_rvalid: got %b want 0000", bus.rvalid_o); n_fail++; end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (bus.rvalid_o !== 4'b0000) begin
      $display("FAIL midrst_after: got %b want 0000", bus.rvalid_o); n_fail++; end
    req = 4'b1111;
    #1;
    n_cmp++; if (bus.gnt_o !== 4'b0001) begin
      $display("FAIL midrst_ptr: got %b want 0001", bus.gnt_o); n_fail++; end
    tick();
    req = '0;
  endtask

  initial begin
    req   = '0;
    we    = '0;
    lock  = '0;
    ram_q = '0;
    for (int k = 0; k < N; k++) begin
      addr[k]  = '0;
      wdata[k] = '0;
    end
    for (int a = 0; a < 65536; a++) mem[a] = '0;
    mem[16'h0010] = 40'hAB_CDEF_0123;
    for (int k = 0; k < N; k++) mem[16'h0020 + k] = 40'h10_0000_00A0 + 40'(k);

    test_reset();
    test_single_read();
    test_contention();
    test_write_read();
    test_lock();
    test_wrap_single();
    test_reset_mid_read();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
